// File: rtl/pa_clint_pkg.sv
// Shared definitions for the CLINT two-port arbiter: FSM state encoding and
// the default downstream timeout.
package pa_clint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pa_clint_arb_rr.sv
// Two-port round-robin picker: on a tie the port that did not win last time
// gets the grant; a sole requester always wins.
module pa_clint_arb_rr (
  input  logic [1:0] reqs,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    if (reqs == 2'b11) begin
      winner = ~last_owner;
    end else if (reqs[1]) begin
      winner = 1'b1;
    end
    if (|reqs) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/pa_clint_arb.sv
// Arbitrates the core TCIP master (port 0) and the debug master (port 1) onto
// the single CLINT register slave, with a bounded wait for completion.
module pa_clint_arb
  import pa_clint_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        p0_req,
  input  logic        p0_write,
  input  logic [15:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_cmplt,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_write,
  input  logic [15:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_cmplt,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        arb_clint_sel,
  output logic        arb_clint_write,
  output logic [15:0] arb_clint_addr,
  output logic [31:0] arb_clint_wdata,
  input  logic        clint_arb_cmplt,
  input  logic [31:0] clint_arb_rdata
);

  localparam logic [4:0] LAST_CNT = 5'(TIMEOUT - 1);

  arb_state_t  state, state_nxt;
  logic [1:0]  grant;
  logic        winner;
  logic        last_owner;
  logic        owner;
  logic        write_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [4:0]  wait_cnt;
  logic        load;
  logic        done_ok;
  logic        done_to;

  pa_clint_arb_rr u_rr (
    .reqs       ({p1_req, p0_req}),
    .last_owner (last_owner),
    .grant      (grant),
    .winner     (winner)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (clint_arb_cmplt) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (wait_cnt == LAST_CNT) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        owner    <= winner;
        write_q  <= winner ? p1_write : p0_write;
        addr_q   <= winner ? p1_addr  : p0_addr;
        wdata_q  <= winner ? p1_wdata : p0_wdata;
        wait_cnt <= '0;
      end else if (state == ISSUE && !clint_arb_cmplt) begin
        wait_cnt <= wait_cnt + 5'd1;
      end
      if (done_ok) begin
        rdata_q    <= write_q ? 32'h0 : clint_arb_rdata;
        err_q      <= 1'b0;
        last_owner <= owner;
      end else if (done_to) begin
        rdata_q    <= 32'h0;
        err_q      <= 1'b1;
        last_owner <= owner;
      end
    end
  end

  // Every output is forced low while reset is held so nothing leaks out
  // before the registers have been initialised.
  assign p0_gnt          = cpurst_b && (state == IDLE) && grant[0];
  assign p1_gnt          = cpurst_b && (state == IDLE) && grant[1];
  assign arb_clint_sel   = cpurst_b && (state == ISSUE);
  assign arb_clint_write = arb_clint_sel && write_q;
  assign arb_clint_addr  = arb_clint_sel ? addr_q  : 16'h0;
  assign arb_clint_wdata = arb_clint_sel ? wdata_q : 32'h0;
  assign p0_cmplt        = cpurst_b && (state == RESP) && !owner;
  assign p1_cmplt        = cpurst_b && (state == RESP) && owner;
  assign p0_rdata        = p0_cmplt ? rdata_q : 32'h0;
  assign p1_rdata        = p1_cmplt ? rdata_q : 32'h0;
  assign p0_err          = p0_cmplt && err_q;
  assign p1_err          = p1_cmplt && err_q;

endmodule

// File: tb/tb_pa_clint_arb.sv
// Self-checking bench for pa_clint_arb: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_pa_clint_arb;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic        rst_n;
    logic        p0_req;
    logic        p0_write;
    logic [15:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p1_req;
    logic        p1_write;
    logic [15:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        cmplt;
    logic [31:0] crdata;
  } stim_t;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        c0;
    logic        c1;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        e0;
    logic        e1;
    logic        sel;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
  } obs_t;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        p0_req = 1'b0, p0_write = 1'b0;
  logic [15:0] p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic        p1_req = 1'b0, p1_write = 1'b0;
  logic [15:0] p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic        clint_arb_cmplt = 1'b0;
  logic [31:0] clint_arb_rdata = '0;
  logic        p0_gnt, p0_cmplt, p0_err, p1_gnt, p1_cmplt, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        arb_clint_sel, arb_clint_write;
  logic [15:0] arb_clint_addr;
  logic [31:0] arb_clint_wdata;

  int total = 0;
  int bad = 0;
  stim_t st;

  // Reference model: one in-flight transaction record plus the tie-break owner.
  bit          t_valid = 1'b0;
  bit          t_done = 1'b0;
  bit          t_owner = 1'b0;
  bit          t_write = 1'b0;
  bit   [15:0] t_addr = '0;
  bit   [31:0] t_wdata = '0;
  bit   [31:0] t_rdata = '0;
  bit          t_err = 1'b0;
  int          t_age = 0;
  bit          m_last = 1'b1;

  pa_clint_arb #(.TIMEOUT(TIMEOUT)) dut (
    .forever_cpuclk  (forever_cpuclk),
    .cpurst_b        (cpurst_b),
    .p0_req          (p0_req),
    .p0_write        (p0_write),
    .p0_addr         (p0_addr),
    .p0_wdata        (p0_wdata),
    .p0_gnt          (p0_gnt),
    .p0_cmplt        (p0_cmplt),
    .p0_rdata        (p0_rdata),
    .p0_err          (p0_err),
    .p1_req          (p1_req),
    .p1_write        (p1_write),
    .p1_addr         (p1_addr),
    .p1_wdata        (p1_wdata),
    .p1_gnt          (p1_gnt),
    .p1_cmplt        (p1_cmplt),
    .p1_rdata        (p1_rdata),
    .p1_err          (p1_err),
    .arb_clint_sel   (arb_clint_sel),
    .arb_clint_write (arb_clint_write),
    .arb_clint_addr  (arb_clint_addr),
    .arb_clint_wdata (arb_clint_wdata),
    .clint_arb_cmplt (clint_arb_cmplt),
    .clint_arb_rdata (clint_arb_rdata)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic checkOutput(input string tag, input obs_t exp);
    obs_t obs;
    obs = '{g0: p0_gnt, g1: p1_gnt, c0: p0_cmplt, c1: p1_cmplt, r0: p0_rdata,
            r1: p1_rdata, e0: p0_err, e1: p1_err, sel: arb_clint_sel,
            wr: arb_clint_write, addr: arb_clint_addr, wd: arb_clint_wdata};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleStim();
    st = '0;
    st.rst_n = 1'b1;
  endtask

  // Drives the staged stimulus for one cycle, checks the DUT against the model,
  // then advances the model to match the coming rising edge.
  task automatic applyStimulus();
    obs_t e;
    bit   w;
    bit   any;
    @(negedge forever_cpuclk);
    cpurst_b        = st.rst_n;
    p0_req          = st.p0_req;
    p0_write        = st.p0_write;
    p0_addr         = st.p0_addr;
    p0_wdata        = st.p0_wdata;
    p1_req          = st.p1_req;
    p1_write        = st.p1_write;
    p1_addr         = st.p1_addr;
    p1_wdata        = st.p1_wdata;
    clint_arb_cmplt = st.cmplt;
    clint_arb_rdata = st.crdata;
    #1;
    e   = '0;
    any = st.p0_req || st.p1_req;
    w   = (st.p0_req && st.p1_req) ? !m_last : st.p1_req;
    if (st.rst_n) begin
      if (!t_valid) begin
        if (any) begin
          if (w) e.g1 = 1'b1;
          else   e.g0 = 1'b1;
        end
      end else if (!t_done) begin
        e.sel  = 1'b1;
        e.wr   = t_write;
        e.addr = t_addr;
        e.wd   = t_wdata;
      end else if (t_owner) begin
        e.c1 = 1'b1;
        e.r1 = t_rdata;
        e.e1 = t_err;
      end else begin
        e.c0 = 1'b1;
        e.r0 = t_rdata;
        e.e0 = t_err;
      end
    end
    checkOutput("model", e);
    if (!st.rst_n) begin
      t_valid = 1'b0;
      t_done  = 1'b0;
      m_last  = 1'b1;
    end else if (!t_valid) begin
      if (any) begin
        t_valid = 1'b1;
        t_done  = 1'b0;
        t_age   = 0;
        t_owner = w;
        t_write = w ? st.p1_write : st.p0_write;
        t_addr  = w ? st.p1_addr  : st.p0_addr;
        t_wdata = w ? st.p1_wdata : st.p0_wdata;
      end
    end else if (!t_done) begin
      if (st.cmplt) begin
        t_done  = 1'b1;
        t_rdata = t_write ? 32'h0 : st.crdata;
        t_err   = 1'b0;
        m_last  = t_owner;
      end else if (t_age + 1 >= TIMEOUT) begin
        t_done  = 1'b1;
        t_rdata = 32'h0;
        t_err   = 1'b1;
        m_last  = t_owner;
      end else begin
        t_age++;
      end
    end else begin
      t_valid = 1'b0;
    end
  endtask

  task automatic drain();
    idleStim();
    st.cmplt = 1'b1;
    repeat (3) applyStimulus();
  endtask

  initial begin
    int  ng;
    int  sel_cnt;
    int  cnt_a;
    int  cnt_b;
    bit  seen;
    bit  last_g;

    $display("[TB] reset");
    idleStim();
    st.rst_n  = 1'b0;
    st.p0_req = 1'b1;
    st.p1_req = 1'b1;
    applyStimulus();
    checkVal("reset_gnt", {30'b0, p1_gnt, p0_gnt}, 0);
    applyStimulus();
    idleStim();
    applyStimulus();
    checkVal("post_reset_sel", arb_clint_sel, 0);

    $display("[TB] single read");
    st.p0_req  = 1'b1;
    st.p0_addr = 16'hbff8;
    applyStimulus();
    checkVal("rd_gnt_T", p0_gnt, 1);
    idleStim();
    st.cmplt  = 1'b1;
    st.crdata = 32'h1234_5678;
    applyStimulus();
    checkVal("rd_sel_T1", arb_clint_sel, 1);
    checkVal("rd_addr_T1", arb_clint_addr, 32'hbff8);
    idleStim();
    applyStimulus();
    checkVal("rd_cmplt_T2", p0_cmplt, 1);
    checkVal("rd_rdata_T2", p0_rdata, 32'h1234_5678);
    checkVal("rd_err_T2", p0_err, 0);

    $display("[TB] contention");
    idleStim();
    st.rst_n = 1'b0;
    applyStimulus();
    st = '{rst_n: 1'b1, p0_req: 1'b1, p0_write: 1'b1, p0_addr: 16'h0010,
           p0_wdata: 32'hA0A0_0000, p1_req: 1'b1, p1_write: 1'b1,
           p1_addr: 16'h0020, p1_wdata: 32'hB1B1_0001, cmplt: 1'b1,
           crdata: 32'hDEAD_BEEF};
    ng     = 0;
    last_g = 1'b0;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      applyStimulus();
      if (arb_clint_sel) begin
        checkVal("cont_sel_addr", arb_clint_addr, last_g ? 32'h0020 : 32'h0010);
        checkVal("cont_sel_wdata", arb_clint_wdata, last_g ? 32'hB1B1_0001 : 32'hA0A0_0000);
      end
      if (p0_gnt || p1_gnt) begin
        checkVal("cont_gnt_order", {31'b0, p1_gnt}, ng % 2);
        last_g = p1_gnt;
        ng++;
      end
    end
    checkVal("cont_ngrants", ng, 4);
    drain();

    $display("[TB] timeout");
    idleStim();
    st.p1_req   = 1'b1;
    st.p1_write = 1'b1;
    st.p1_addr  = 16'h4000;
    st.p1_wdata = 32'h0000_0077;
    applyStimulus();
    checkVal("to_gnt", p1_gnt, 1);
    idleStim();
    sel_cnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus();
      if (arb_clint_sel) sel_cnt++;
      if (p1_cmplt) begin
        seen = 1'b1;
        checkVal("to_err", p1_err, 1);
        checkVal("to_rdata", p1_rdata, 0);
      end
    end
    checkVal("to_seen_cmplt", seen, 1);
    checkVal("to_sel_cycles", sel_cnt, TIMEOUT);
    st.p0_req = 1'b1;
    applyStimulus();
    checkVal("to_next_gnt", p0_gnt, 1);
    idleStim();
    st.cmplt  = 1'b1;
    st.crdata = 32'h0000_00AA;
    applyStimulus();
    idleStim();
    applyStimulus();
    checkVal("to_next_err", p0_err, 0);
    checkVal("to_next_rdata", p0_rdata, 32'h0000_00AA);

    $display("[TB] wait states");
    idleStim();
    st.p0_req  = 1'b1;
    st.p0_addr = 16'h0004;
    applyStimulus();
    checkVal("ws_gnt", p0_gnt, 1);
    idleStim();
    applyStimulus();
    st.p0_req  = 1'b1;
    st.p0_addr = 16'h0008;
    applyStimulus();
    checkVal("ws_no_gnt_issue", p0_gnt, 0);
    st.cmplt  = 1'b1;
    st.crdata = 32'hCAFE_0001;
    applyStimulus();
    checkVal("ws_sel3", arb_clint_sel, 1);
    checkVal("ws_addr", arb_clint_addr, 32'h0004);
    st.cmplt = 1'b0;
    applyStimulus();
    checkVal("ws_no_gnt_resp", p0_gnt, 0);
    checkVal("ws_cmplt", p0_cmplt, 1);
    checkVal("ws_rdata", p0_rdata, 32'hCAFE_0001);
    checkVal("ws_err", p0_err, 0);
    applyStimulus();
    checkVal("ws_gnt_idle", p0_gnt, 1);
    drain();

    $display("[TB] reset mid-issue");
    idleStim();
    st.p1_req = 1'b1;
    applyStimulus();
    idleStim();
    applyStimulus();
    checkVal("rst_in_issue", arb_clint_sel, 1);
    st.rst_n = 1'b0;
    st.cmplt = 1'b1;
    applyStimulus();
    checkVal("rst_sel_low", arb_clint_sel, 0);
    idleStim();
    st.cmplt = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (p0_cmplt || p1_cmplt || arb_clint_sel) cnt_a++;
    end
    checkVal("rst_no_cmplt", cnt_a, 0);
    st.p0_req = 1'b1;
    st.p1_req = 1'b1;
    applyStimulus();
    checkVal("rst_tie_p0", {30'b0, p1_gnt, p0_gnt}, 1);
    drain();

    $display("[TB] withdrawn request");
    idleStim();
    st.p0_req  = 1'b1;
    st.p0_addr = 16'h0100;
    applyStimulus();
    idleStim();
    st.p1_req  = 1'b1;
    st.p1_addr = 16'h0200;
    cnt_a = 0;
    cnt_b = 0;
    applyStimulus();
    if (p1_gnt) cnt_a++;
    idleStim();
    st.cmplt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      if (p1_gnt) cnt_a++;
      if (arb_clint_sel && arb_clint_addr == 16'h0200) cnt_b++;
    end
    checkVal("wd_no_p1_gnt", cnt_a, 0);
    checkVal("wd_no_access", cnt_b, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      st.rst_n    = ($urandom_range(0, 79) != 0);
      st.p0_req   = ($urandom_range(0, 2) == 0);
      st.p0_write = $urandom_range(0, 1) == 1;
      st.p0_addr  = 16'($urandom);
      st.p0_wdata = $urandom;
      st.p1_req   = ($urandom_range(0, 2) == 0);
      st.p1_write = $urandom_range(0, 1) == 1;
      st.p1_addr  = 16'($urandom);
      st.p1_wdata = $urandom;
      st.cmplt    = ($urandom_range(0, 4) == 0);
      st.crdata   = $urandom;
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
